// File: rtl/vga_clk_nco_gen_pkg.sv
// Shared types and constants for the NCO clock-enable generator.
// Also provides the width helper for the lock counter.
package vga_clk_pkg;

    // Top-level lock/config state machine.
    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        LOCKED = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Increments for common pixel rates from a 50 MHz reference, 32-bit accumulator.
    localparam logic [31:0] INCR_25M_AT_50M = 32'h80000000;
    localparam logic [31:0] INCR_33M_AT_50M = 32'hA8F5C28F;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits = bits + 1;
        end
        if (bits < 1) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/vga_clk_nco_gen_if.sv
// Configuration port of the NCO generator: valid/ready request carrying a
// channel index and a new increment, plus the out-of-range error pulse.
interface vga_clk_nco_gen_if #(
    parameter int ACC_W = 32
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [3:0]       cfg_chan;
    logic [ACC_W-1:0] cfg_incr;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_incr,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_incr,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/vga_clk_nco_gen_chan.sv
// One NCO channel: phase accumulator plus increment register. The registered
// carry of acc + incr is the channel's clock-enable strobe.
// clr zeroes the accumulator and the strobe; load replaces the increment,
// which takes effect from the following cycle.
module vga_clk_nco_chan #(
    parameter int               ACC_W      = 32,
    parameter logic [ACC_W-1:0] RESET_INCR = '0
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [ACC_W-1:0] load_incr,
    output logic             ce
);
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] incr;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, incr};

    // Increment register: reprogrammed only on a load.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            incr <= RESET_INCR;
        end else if (load) begin
            incr <= load_incr;
        end
    end

    // Accumulate every cycle; the carry becomes next cycle's strobe.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            ce  <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            ce  <= 1'b0;
        end else begin
            acc <= sum[ACC_W-1:0];
            ce  <= sum[ACC_W];
        end
    end
endmodule

// File: rtl/vga_clk_nco_gen.sv
// N-channel fractional clock-enable generator. Each channel strobes at
// f_ref * incr / 2^ACC_W. Increments are reprogrammed via the cfg port;
// locked drops while a change is applied and for LOCK_CYCLES afterwards.
// Optional build macro VGA_CLK_NCO_PHASE_ALIGN_EN: an update clears every
// accumulator so all channels restart phase-aligned; otherwise only the
// target channel is cleared.
module vga_clk_nco_gen
    import vga_clk_pkg::*;
#(
    parameter int                          NUM_CLOCKS  = 3,
    parameter int                          ACC_W       = 32,
    parameter int                          LOCK_CYCLES = 1024,
    parameter logic [NUM_CLOCKS*ACC_W-1:0] RESET_INCR  =
        {INCR_25M_AT_50M, INCR_25M_AT_50M, INCR_33M_AT_50M}
) (
    input  logic                  refclk,
    input  logic                  rst,
    vga_clk_nco_gen_if.slave      cfg,
    output logic [NUM_CLOCKS-1:0] ce_out,
    output logic                  locked
);
    localparam int               CNT_W      = clog2(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LOCK_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       chan_q;
    logic [ACC_W-1:0] incr_q;
    logic             accept;
    logic             in_range;
    logic             upd;

    assign accept   = cfg.cfg_valid && cfg.cfg_ready;
    assign in_range = int'(cfg.cfg_chan) < NUM_CLOCKS;
    assign upd      = (state == UPDATE);

    // Out-of-range requests are still accepted; they only raise a one-cycle error.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            cfg.cfg_err <= 1'b0;
        end else begin
            cfg.cfg_err <= accept && !in_range;
        end
    end

    // Lock FSM. cfg_ready drops for one cycle after any accept, so accepts are
    // at least two cycles apart; an in-range accept spends that cycle in UPDATE.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state         <= SETTLE;
            cnt           <= CNT_RELOAD;
            locked        <= 1'b0;
            cfg.cfg_ready <= 1'b0;
            chan_q        <= '0;
            incr_q        <= '0;
        end else begin
            case (state)
                SETTLE, LOCKED: begin
                    if (accept && in_range) begin
                        state         <= UPDATE;
                        locked        <= 1'b0;
                        cfg.cfg_ready <= 1'b0;
                        chan_q        <= cfg.cfg_chan;
                        incr_q        <= cfg.cfg_incr;
                    end else begin
                        cfg.cfg_ready <= !accept;
                        if (state == SETTLE) begin
                            if (cnt == '0) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                cnt <= cnt - 1'b1;
                            end
                        end
                    end
                end
                UPDATE: begin
                    state         <= SETTLE;
                    cnt           <= CNT_RELOAD;
                    locked        <= 1'b0;
                    cfg.cfg_ready <= 1'b1;
                end
                default: begin
                    state         <= SETTLE;
                    cnt           <= CNT_RELOAD;
                    locked        <= 1'b0;
                    cfg.cfg_ready <= 1'b0;
                end
            endcase
        end
    end

    // Channel array: load the target during UPDATE and clear its phase
    // (or every channel's phase when phase alignment is built in).
    for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
        logic hit;
        logic clr;

        assign hit = upd && (chan_q == 4'(i));
`ifdef VGA_CLK_NCO_PHASE_ALIGN_EN
        assign clr = upd;
`else
        assign clr = hit;
`endif

        vga_clk_nco_chan #(
            .ACC_W      (ACC_W),
            .RESET_INCR (RESET_INCR[i*ACC_W +: ACC_W])
        ) u_chan (
            .refclk    (refclk),
            .rst       (rst),
            .clr       (clr),
            .load      (hit),
            .load_incr (incr_q),
            .ce        (ce_out[i])
        );
    end
endmodule
